iline_refill: RTL and testbench

Instruction-cache line-refill engine sitting directly downstream of the I-cache miss FSM and upstream of the Wishbone bus interface unit. On a miss request it issues an 8-beat incrementing Wishbone burst for the line-aligned address, assembles the returned 32-bit words into a 256-bit line, and returns the line to the cache with a one-cycle valid pulse. It also reports bus errors so the cache FSM can abandon the fill.

---
 rtl/iside_pkg.sv | 16 +
 rtl/iline_refill.sv | 126 ++++++++++++
 tb/tb_iline_refill.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iside_pkg.sv
// Shared I-side definitions for the instruction-cache refill path.
// Holds the cache line geometry and the refill FSM state encoding.
package iside_pkg;

    localparam int LINE_WORDS    = 8;    // 32-bit beats per cache line
    localparam int LINE_BITS     = 256;  // line width in bits
    localparam int LINE_OFF_BITS = 5;    // byte-offset bits inside a line

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_DONE  = 2'b10,
        ST_ERR   = 2'b11
    } refill_state_e;

endpackage

// File: rtl/iline_refill.sv
// Instruction-cache line-refill engine.
// Accepts a one-cycle miss request and issues a WORDS-beat incrementing
// Wishbone burst for the line-aligned address. It collects the returned words
// into one line and signals the cache with a one-cycle line_valid pulse, or
// with a one-cycle fill_err pulse if the slave reports a bus error.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-high reset (name is historical)
//   fill_req, fill_addr miss request and miss address (line offset ignored)
//   fill_busy           engine is not idle
//   line_valid          one-cycle pulse, line_o holds a complete line
//   fill_err            one-cycle pulse, burst aborted by wb_err_i
//   line_o              assembled line, word k at [DW*k +: DW]
//   wb_*                Wishbone burst master signals
module iline_refill
    import iside_pkg::*;
#(
    parameter int WORDS = LINE_WORDS,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fill_req,
    input  logic [AW-1:0]       fill_addr,
    output logic                fill_busy,
    output logic                line_valid,
    output logic                fill_err,
    output logic [WORDS*DW-1:0] line_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_cab_o,
    output logic [DW/8-1:0]     wb_sel_o,
    output logic [AW-1:0]       wb_adr_o,
    input  logic [DW-1:0]       wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);

    localparam int BEAT_W = $clog2(WORDS);
    localparam int BYTE_W = $clog2(DW / 8);
    localparam int OFF_W  = BEAT_W + BYTE_W;
    localparam int BASE_W = AW - OFF_W;

    refill_state_e         state_q;
    refill_state_e         state_d;
    logic [BEAT_W-1:0]     beat_q;
    logic [BASE_W-1:0]     base_q;
    logic [DW-1:0]         words_q [WORDS];

    // Line-offset bits of the miss address are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^fill_addr[OFF_W-1:0];

    wire good_ack  = wb_ack_i && !wb_err_i;
    wire last_beat = (beat_q == BEAT_W'(WORDS - 1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every output is decoded from registered state and registers only, so
    // no combinational path runs from wb_ack_i/wb_err_i to the bus outputs.
    always_comb begin
        state_d    = state_q;
        fill_busy  = (state_q != ST_IDLE);
        line_valid = 1'b0;
        fill_err   = 1'b0;
        wb_cyc_o   = 1'b0;
        wb_stb_o   = 1'b0;
        wb_cab_o   = 1'b0;
        wb_sel_o   = '0;
        wb_adr_o   = '0;
        case (state_q)
            ST_IDLE: begin
                if (fill_req) state_d = ST_BURST;
            end
            ST_BURST: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_cab_o = 1'b1;
                wb_sel_o = '1;
                wb_adr_o = {base_q, beat_q, {BYTE_W{1'b0}}};
                // An error beats a same-cycle ack.
                if (wb_err_i)                  state_d = ST_ERR;
                else if (wb_ack_i && last_beat) state_d = ST_DONE;
            end
            ST_DONE: begin
                line_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_ERR: begin
                fill_err = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Words are overwritten one beat at a time, so the previous line stays
    // visible until the first ack of the next fill.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            beat_q <= '0;
            base_q <= '0;
            for (int k = 0; k < WORDS; k++) words_q[k] <= '0;
        end else begin
            if (state_q == ST_IDLE && fill_req) begin
                base_q <= fill_addr[AW-1:OFF_W];
                beat_q <= '0;
            end else if (state_q == ST_BURST && good_ack) begin
                words_q[beat_q] <= wb_dat_i;
                beat_q          <= beat_q + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < WORDS; k++) begin : g_line
        assign line_o[DW*k +: DW] = words_q[k];
    end

endmodule

// File: tb/tb_iline_refill.sv
module tb_iline_refill;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fill_req;
    logic [31:0]  fill_addr;
    logic         fill_busy;
    logic         line_valid;
    logic         fill_err;
    logic [255:0] line_o;
    logic         wb_cyc_o, wb_stb_o, wb_cab_o;
    logic [3:0]   wb_sel_o;
    logic [31:0]  wb_adr_o;
    logic [31:0]  wb_dat_i;
    logic         wb_ack_i, wb_err_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iline_refill dut (
        .clk(clk), .rst_n(rst_n), .fill_req(fill_req), .fill_addr(fill_addr),
        .fill_busy(fill_busy), .line_valid(line_valid), .fill_err(fill_err),
        .line_o(line_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cab_o(wb_cab_o), .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    // Slave data for the current fill, one word per beat.
    logic [31:0] beat_data [8];

    // Observations of the last fill.
    int           r_valid, r_err, r_idle, r_acked, r_bad, r_rises;
    logic         r_cyc_in_err;
    logic [255:0] r_line, r_line_c1;

    function automatic logic [255:0] model_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = beat_data[k];
        return l;
    endfunction

    task automatic randomize_data();
        for (int k = 0; k < 8; k++) beat_data[k] = $urandom;
    endtask

    // Called at a negedge: that cycle is cycle 0 of the request. Acts as a
    // Wishbone slave acking every 'period'-th bus cycle, optionally raising
    // err with the ack of beat 'err_beat', optionally pulsing fill_req again
    // in cycle 'busy_req'. Stops at the first cycle fill_busy is low.
    task automatic run_fill(input logic [31:0] addr, input int period,
                            input int err_beat, input int busy_req);
        int   bc, beat;
        logic prev_cyc;
        r_valid = -1; r_err = -1; r_idle = -1; r_acked = 0; r_bad = 0;
        r_rises = 0; r_cyc_in_err = 1'bx; r_line = '0; r_line_c1 = '0;
        bc = 0; beat = 0; prev_cyc = 1'b0;
        fill_req  = 1'b1;
        fill_addr = addr;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            fill_req  = (c == busy_req);
            fill_addr = $urandom;
            wb_ack_i  = 1'b0;
            wb_err_i  = 1'b0;
            wb_dat_i  = $urandom;
            if (c == 1) r_line_c1 = line_o;
            if (wb_cyc_o && !prev_cyc) r_rises++;
            prev_cyc = wb_cyc_o;
            if (line_valid) begin r_valid = c; r_line = line_o; end
            if (fill_err) begin r_err = c; r_cyc_in_err = wb_cyc_o; end
            if (!fill_busy) begin r_idle = c; break; end
            if (wb_cyc_o) begin
                bc++;
                if (wb_adr_o !== {addr[31:5], beat[2:0], 2'b00} || wb_stb_o !== 1'b1 ||
                    wb_cab_o !== 1'b1 || wb_sel_o !== 4'hF) r_bad++;
                if (bc % period == 0) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = beat_data[beat % 8];
                    if (beat == err_beat) wb_err_i = 1'b1;
                    else begin beat++; r_acked++; end
                end
            end else if (wb_stb_o !== 1'b0 || wb_cab_o !== 1'b0 ||
                         wb_sel_o !== 4'h0 || wb_adr_o !== 32'h0) begin
                r_bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; fill_req = 1'b0; fill_addr = 32'hFFFF_FFFF;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({fill_busy, line_valid, fill_err, wb_cyc_o, wb_stb_o, wb_cab_o} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
                {fill_busy, line_valid, fill_err, wb_cyc_o, wb_stb_o, wb_cab_o});
        end
        n_checks++;
        if (wb_adr_o !== 32'h0 || wb_sel_o !== 4'h0) begin
            n_fail++; $display("FAIL reset_bus: adr %h sel %h want 0", wb_adr_o, wb_sel_o);
        end
        n_checks++;
        if (line_o !== 256'h0) begin
            n_fail++; $display("FAIL reset_line: got %h want 0", line_o);
        end
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        logic [255:0] exp_line;
        exp_line = 256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0;
        for (int k = 0; k < 8; k++) beat_data[k] = 32'hA0 + k;
        run_fill(32'h0000_1234, 1, -1, -1);
        n_checks++;
        if (r_valid !== 9) begin n_fail++; $display("FAIL zw_valid_cycle: got %0d want 9", r_valid); end
        n_checks++;
        if (r_idle !== 10) begin n_fail++; $display("FAIL zw_idle_cycle: got %0d want 10", r_idle); end
        n_checks++;
        if (r_line !== exp_line) begin n_fail++; $display("FAIL zw_line: got %h want %h", r_line, exp_line); end
        n_checks++;
        if (r_bad !== 0) begin n_fail++; $display("FAIL zw_bus: got %0d bad cycles want 0", r_bad); end
        n_checks++;
        if (r_acked !== 8 || r_err !== -1) begin
            n_fail++; $display("FAIL zw_beats: acked %0d err %0d want 8 -1", r_acked, r_err);
        end
    endtask

    task automatic test_wait_states();
        randomize_data();
        run_fill(32'h8000_0F5C, 3, -1, -1);
        n_checks++;
        if (r_valid !== 25) begin n_fail++; $display("FAIL ws_valid_cycle: got %0d want 25", r_valid); end
        n_checks++;
        if (r_line !== model_line()) begin n_fail++; $display("FAIL ws_line: got %h want %h", r_line, model_line()); end
        n_checks++;
        if (r_bad !== 0) begin n_fail++; $display("FAIL ws_adr_stable: got %0d bad cycles want 0", r_bad); end
    endtask

    task automatic test_bus_error();
        randomize_data();
        run_fill(32'h0040_0000, 1, 4, -1);
        n_checks++;
        if (r_err !== 6) begin n_fail++; $display("FAIL err_cycle: got %0d want 6", r_err); end
        n_checks++;
        if (r_valid !== -1) begin n_fail++; $display("FAIL err_no_valid: got %0d want -1", r_valid); end
        n_checks++;
        if (r_cyc_in_err !== 1'b0) begin n_fail++; $display("FAIL err_cyc_low: got %b want 0", r_cyc_in_err); end
        n_checks++;
        if (r_idle !== 7) begin n_fail++; $display("FAIL err_idle_cycle: got %0d want 7", r_idle); end
        randomize_data();
        run_fill(32'h0040_0020, 1, -1, -1);
        n_checks++;
        if (r_valid !== 9 || r_line !== model_line() || r_bad !== 0) begin
            n_fail++; $display("FAIL err_recover: valid %0d bad %0d line %h want 9 0 %h",
                r_valid, r_bad, r_line, model_line());
        end
    endtask

    task automatic test_busy_request();
        randomize_data();
        run_fill(32'h1234_5678, 1, -1, 3);
        n_checks++;
        if (r_rises !== 1 || r_acked !== 8) begin
            n_fail++; $display("FAIL busy_req_bursts: rises %0d beats %0d want 1 8", r_rises, r_acked);
        end
        n_checks++;
        if (r_valid !== 9 || r_line !== model_line()) begin
            n_fail++; $display("FAIL busy_req_line: valid %0d line %h want 9 %h", r_valid, r_line, model_line());
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (wb_cyc_o !== 1'b0 || fill_busy !== 1'b0) begin
                n_fail++; $display("FAIL busy_req_queued: cyc %b busy %b want 0 0", wb_cyc_o, fill_busy);
            end
        end
    endtask

    task automatic test_async_reset();
        randomize_data();
        fill_req = 1'b1; fill_addr = 32'hCAFE_0000;
        @(negedge clk);
        fill_req = 1'b0;
        for (int b = 0; b < 5; b++) begin
            wb_ack_i = 1'b1; wb_dat_i = beat_data[b];
            @(negedge clk);
        end
        wb_ack_i = 1'b0;
        n_checks++;
        if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'hCAFE_0014) begin
            n_fail++; $display("FAIL ar_pre: cyc %b adr %h want 1 cafe0014", wb_cyc_o, wb_adr_o);
        end
        #2 rst_n = 1'b1;
        #1;
        n_checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
            n_fail++; $display("FAIL ar_cyc_drop: cyc %b stb %b want 0 0", wb_cyc_o, wb_stb_o);
        end
        n_checks++;
        if (line_o !== 256'h0 || fill_busy !== 1'b0) begin
            n_fail++; $display("FAIL ar_state: busy %b line %h want 0 0", fill_busy, line_o);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        randomize_data();
        run_fill(32'hCAFE_0000, 1, -1, -1);
        n_checks++;
        if (r_bad !== 0 || r_valid !== 9 || r_line !== model_line()) begin
            n_fail++; $display("FAIL ar_restart: bad %0d valid %0d line %h want 0 9 %h",
                r_bad, r_valid, r_line, model_line());
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] first;
        randomize_data();
        run_fill(32'h0000_2000, 1, -1, -1);
        first = model_line();
        n_checks++;
        if (r_line !== first) begin n_fail++; $display("FAIL b2b_first: got %h want %h", r_line, first); end
        randomize_data();
        run_fill(32'h0000_3040, 1, -1, -1);
        n_checks++;
        if (r_line_c1 !== first) begin
            n_fail++; $display("FAIL b2b_hold: got %h want %h", r_line_c1, first);
        end
        n_checks++;
        if (r_valid !== 9 || r_rises !== 1 || r_bad !== 0 || r_line !== model_line()) begin
            n_fail++; $display("FAIL b2b_second: valid %0d rises %0d bad %0d line %h want 9 1 0 %h",
                r_valid, r_rises, r_bad, r_line, model_line());
        end
    endtask

    task automatic test_random();
        int p;
        for (int i = 0; i < 6; i++) begin
            randomize_data();
            p = $urandom_range(1, 4);
            run_fill($urandom, p, -1, -1);
            n_checks++;
            if (r_valid !== 8 * p + 1 || r_idle !== 8 * p + 2 || r_bad !== 0 || r_line !== model_line()) begin
                n_fail++; $display("FAIL rnd_fill%0d: valid %0d idle %0d bad %0d want %0d %0d 0",
                    i, r_valid, r_idle, r_bad, 8 * p + 1, 8 * p + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_bus_error();
        test_busy_request();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
